regfile_2r1w: RTL and testbench

Parametrised register file built from a bank of enable-gated registers: two combinational read ports and one synchronous write port, with an optional hardwired-zero register and optional write-to-read forwarding. It is the successor to the single 64-bit enable register and forms the architectural register file of the datapath. Instruction decode drives the read ports and writeback drives the write port.

---
 rtl/regfile_2r1w.sv | 77 +++++++
 tb/tb_regfile_2r1w.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read, one-write architectural register file with an optional hardwired-zero top register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_2r1w #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W+1)'(DEPTH - 1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;

    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] ax;
        ax = {1'b0, a};
        return (ax < DEPTH_X) && !((ZERO_REG != 0) && (ax == LAST_X));
    endfunction

    assign wr_ok = wr_en && !reset && addr_live(wr_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Dead addresses and reset force zero; forwarding only reaches live addresses.
    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] d;
        d = '0;
        if (!reset && addr_live(a)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a == ADDR_W'(i)) begin
                    d = regs[i];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (a == wr_addr)) begin
                d = wr_data;
            end
`else
`endif
        end
        return d;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
    end

    always_comb begin
        rd_data_b = read_port(rd_addr_b);
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w: a default 32-entry instance plus a 16-entry one.
// Collision expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_2r1w;

    localparam logic [63:0] K = 64'h0000010204080001;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_b;

    logic        s_wr_en;
    logic [4:0]  s_wr_addr;
    logic [63:0] s_wr_data;
    logic [4:0]  s_rd_addr_a;
    logic [63:0] s_rd_data_a;
    logic [4:0]  s_rd_addr_b;
    logic [63:0] s_rd_data_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_2r1w u_dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    regfile_2r1w #(.WIDTH(64), .DEPTH(16), .ADDR_W(5), .ZERO_REG(1)) u_small (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (s_wr_en),
        .wr_addr   (s_wr_addr),
        .wr_data   (s_wr_data),
        .rd_addr_a (s_rd_addr_a),
        .rd_data_a (s_rd_data_a),
        .rd_addr_b (s_rd_addr_b),
        .rd_data_b (s_rd_data_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One write edge on the main instance, inputs changed on the falling edge.
    task automatic applyStimulus(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic applySmall(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clk);
        s_wr_en   = 1'b1;
        s_wr_addr = addr;
        s_wr_data = data;
        @(negedge clk);
        s_wr_en   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr_a = 5'd3; rd_addr_b = 5'd0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr_a = '0; s_rd_addr_b = '0;
        #2;
        checkOutput("reset_a", rd_data_a, 64'h0);
        checkOutput("reset_b", rd_data_b, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset clears a freshly written register mid-cycle.
        applyStimulus(5'd3, 64'hDEADBEEF_00000001);
        #1;
        checkOutput("wr_reg3", rd_data_a, 64'hDEADBEEF_00000001);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_clr_reg3", rd_data_a, 64'h0);
        #1 reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            applyStimulus(5'(i), 64'(i) * K);
        end
        #1;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            #1;
            checkOutput($sformatf("sweep_a[%0d]", i), rd_data_a, (i == 31) ? 64'h0 : 64'(i) * K);
            checkOutput($sformatf("sweep_b[%0d]", 31 - i), rd_data_b, (i == 0) ? 64'h0 : 64'(31 - i) * K);
        end

        // Enable gating on reg 5.
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 5'd5; wr_data = '1;
        repeat (10) @(negedge clk);
        rd_addr_a = 5'd5; rd_addr_b = 5'd4;
        #1;
        checkOutput("gated_reg5", rd_data_a, 64'd5 * K);
        applyStimulus(5'd5, '1);
        #1;
        checkOutput("enabled_reg5", rd_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("neighbour_reg4", rd_data_b, 64'd4 * K);
        rd_addr_b = 5'd6;
        #1;
        checkOutput("neighbour_reg6", rd_data_b, 64'd6 * K);

        // Zero register is never written and never forwarded.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234; rd_addr_b = 5'd31;
        #1;
        checkOutput("zero_reg_same_cycle", rd_data_b, 64'h0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        checkOutput("zero_reg_after", rd_data_b, 64'h0);

        // Out-of-range and top-register writes on the 16-entry instance.
        applySmall(5'd20, 64'hCAFE);
        applySmall(5'd14, 64'h0E0E);
        applySmall(5'd15, 64'h0F0F);
        s_rd_addr_a = 5'd20; s_rd_addr_b = 5'd4;
        #1;
        checkOutput("small_oor_20", s_rd_data_a, 64'h0);
        checkOutput("small_alias_4", s_rd_data_b, 64'h0);
        s_rd_addr_a = 5'd14; s_rd_addr_b = 5'd15;
        #1;
        checkOutput("small_reg14", s_rd_data_a, 64'h0E0E);
        checkOutput("small_zero15", s_rd_data_b, 64'h0);

        // Same-address read/write collision on reg 7.
        applyStimulus(5'd7, 64'hA);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hB; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("collide_a_before", rd_data_a, 64'hB);
        checkOutput("collide_b_before", rd_data_b, 64'hB);
`else
        checkOutput("collide_a_before", rd_data_a, 64'hA);
        checkOutput("collide_b_before", rd_data_b, 64'hA);
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        checkOutput("collide_a_after", rd_data_a, 64'hB);
        checkOutput("collide_b_after", rd_data_b, 64'hB);

        // Write pending across a reset edge is discarded.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'h55; reset = 1'b1; rd_addr_a = 5'd2; rd_addr_b = 5'd5;
        #1;
        checkOutput("reset_read_block", rd_data_a, 64'h0);
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        #1;
        checkOutput("reset_write_drop", rd_data_a, 64'h0);
        checkOutput("reset_clr_reg5", rd_data_b, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
